// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the FIR frame sequencer
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        CAPT,
        HOLD,
        DONE
    } fir_state_e;

    localparam int SAMPLE_W   = 16;
    // FIR data_valid pulses needed before its first valid result
    localparam int FIR_WARMUP = 33;

endpackage

// File: rtl/fir_sample_fifo.sv
// rtl/fir_sample_fifo.sv - power-of-two sample FIFO with full/empty flags
module fir_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Sample storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_frame_ctrl.sv
// rtl/fir_frame_ctrl.sv - frame sequencer feeding the FIR; optional stall counter under FIR_FRAME_CTRL_STATS_EN
module fir_frame_ctrl
    import fir_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    frame_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                fir_data_valid,
    output logic [SAMPLE_W-1:0] fir_data,
    input  logic                fir_valid,
    input  logic [SAMPLE_W-1:0] fir_d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                out_last,
    output logic                busy,
`ifdef FIR_FRAME_CTRL_STATS_EN
    output logic [15:0]         stall_cnt,
`endif
    output logic                done
);

    fir_state_e          state;
    fir_state_e          state_next;
    logic [LEN_W-1:0]    remaining;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;

    fir_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready = !fifo_full;

    // Next-state and FIFO pop decision.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (frame_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = CAPT;
            CAPT: begin
                if (fir_valid) begin
                    state_next = HOLD;
                end else begin
                    state_next = (remaining == '0) ? DONE : FETCH;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = (remaining == '0) ? DONE : FETCH;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, frame counter and registered outputs; strobes are derived from
    // the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            remaining      <= '0;
            fir_data_valid <= 1'b0;
            fir_data       <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_last       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_next;
            fir_data_valid <= (state_next == ISSUE);
            busy           <= (state_next != IDLE);
            done           <= (state_next == DONE);
            if (state == IDLE && start) begin
                remaining <= frame_len;
            end
            if (pop) begin
                fir_data  <= fifo_head;
                remaining <= remaining - LEN_W'(1);
            end
            if (state == CAPT && fir_valid) begin
                out_valid <= 1'b1;
                out_data  <= fir_d;
                out_last  <= (remaining == '0);
            end
            if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef FIR_FRAME_CTRL_STATS_EN
    // Cycles a presented beat waits on downstream; saturates, restarts per frame.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
